// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - program RAM loader with host stream and processor fetch port.
// Optional trailing checksum word check is enabled by defining PROG_CHECKSUM_EN.
module prog_mem_loader #(
    parameter int          DEPTH     = 1024,
    parameter int          ADDR_W    = 10,
    parameter logic [15:0] FILL_WORD = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [ADDR_W:0]   load_len,
    input  logic              host_vld,
    input  logic [15:0]       host_data,
    output logic              host_rdy,
    output logic              load_done,
    output logic              load_err,
    input  logic [ADDR_W-1:0] pc,
    input  logic              ram_read_en,
    output logic [15:0]       data_in,
    output logic              data_vld,
    output logic              start,
    output logic              running
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef PROG_CHECKSUM_EN
        S_CHECK,
`endif
        S_LAUNCH,
        S_RUN
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    state_t          state, state_n;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] prog_len;
    logic [15:0]     ram [DEPTH];

    logic req_ok, req_taken, xfer, last_word, fetch_go;

    assign req_ok    = (load_len != '0) && (load_len <= DEPTH_W);
    // Requests are only acted on from IDLE or RUN; LOAD ignores them.
    assign req_taken = load_req && ((state == S_IDLE) || (state == S_RUN));
    assign xfer      = host_vld && host_rdy;
    assign last_word = xfer && (state == S_LOAD) && (wr_ptr == len - 1'b1);
    assign fetch_go  = (state == S_RUN) && ram_read_en && !(load_req && req_ok);
    assign running   = (state == S_RUN);

`ifdef PROG_CHECKSUM_EN
    logic [15:0] sum;
    logic        chk_pass, chk_fail;
    assign chk_pass = xfer && (state == S_CHECK) && (host_data == sum);
    assign chk_fail = xfer && (state == S_CHECK) && (host_data != sum);
`endif

    always_comb begin
        state_n  = state;
        host_rdy = 1'b0;
        case (state)
            S_IDLE: if (load_req && req_ok) state_n = S_LOAD;
            S_LOAD: begin
                host_rdy = 1'b1;
`ifdef PROG_CHECKSUM_EN
                if (last_word) state_n = S_CHECK;
`else
                if (last_word) state_n = S_LAUNCH;
`endif
            end
`ifdef PROG_CHECKSUM_EN
            S_CHECK: begin
                host_rdy = 1'b1;
                if (chk_pass)      state_n = S_LAUNCH;
                else if (chk_fail) state_n = S_IDLE;
            end
`endif
            S_LAUNCH: state_n = S_RUN;
            S_RUN:    if (load_req && req_ok) state_n = S_LOAD;
            default:  state_n = S_IDLE;
        endcase
    end

    // RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (xfer && (state == S_LOAD)) ram[wr_ptr[ADDR_W-1:0]] <= host_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len       <= '0;
            wr_ptr    <= '0;
            prog_len  <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            start     <= 1'b0;
            data_vld  <= 1'b0;
            data_in   <= '0;
`ifdef PROG_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            state <= state_n;
            if (req_taken && req_ok) begin
                len    <= load_len;
                wr_ptr <= '0;
`ifdef PROG_CHECKSUM_EN
                sum    <= '0;
`endif
            end
            if (xfer && (state == S_LOAD)) begin
                wr_ptr <= wr_ptr + 1'b1;
`ifdef PROG_CHECKSUM_EN
                sum    <= sum + host_data;
`endif
            end
            if (last_word) prog_len <= len;
`ifdef PROG_CHECKSUM_EN
            if (chk_fail) prog_len <= '0;
            load_done <= chk_pass;
            load_err  <= (req_taken && !req_ok) || chk_fail;
`else
            load_done <= last_word;
            load_err  <= req_taken && !req_ok;
`endif
            start    <= (state == S_LAUNCH);
            data_vld <= fetch_go;
            if (fetch_go) data_in <= ({1'b0, pc} < prog_len) ? ram[pc] : FILL_WORD;
        end
    end

endmodule
